// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate sequencing logic.
package parking_pkg;

  // Lifecycle of one barrier: idle, refused, raised, committing, lowered.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DENY   = 3'd1,
    OPEN   = 3'd2,
    COMMIT = 3'd3,
    CLOSE  = 3'd4
  } gate_state_e;

  localparam logic CLASS_PUBLIC = 1'b0;
  localparam logic CLASS_UNI    = 1'b1;

  localparam int DEFAULT_PASS_TIMEOUT = 16;

endpackage

// File: rtl/gate_fsm.sv
// One barrier lane: admits or refuses the waiting car, holds the gate open
// until the car passes or the timeout expires, then requests a commit slot.
//
// Commit handshake: commit_req is high in the cycle a pass is seen in OPEN
// and in every COMMIT cycle not yet granted. A cycle with commit_req=1 and
// grant=1 is the transfer; the owner of the update pulse registers it on
// that edge, and this lane never requests again for the same car.
module gate_fsm
  import parking_pkg::*;
#(
  parameter int PASS_TIMEOUT = DEFAULT_PASS_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       is_uni,
  input  logic       permit,
  input  logic       pass,
  input  logic       grant,
  output logic       gate_open,
  output logic       denied,
  output logic       commit_req,
  output logic       car_class,
  output logic [2:0] state_dbg
);

  localparam logic [7:0] TIMEOUT_INIT = 8'(PASS_TIMEOUT);

  gate_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        class_q, class_d;
  logic        granted_q, granted_d;

  // State register with the timeout counter, latched class and grant memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      class_q   <= CLASS_PUBLIC;
      granted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      class_q   <= class_d;
      granted_q <= granted_d;
    end
  end

  // Next-state logic; a pass pulse beats the expiring timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    class_d   = class_q;
    granted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && permit) begin
          state_d = OPEN;
          cnt_d   = TIMEOUT_INIT;
          class_d = is_uni;
        end else if (req) begin
          state_d = DENY;
        end
      end
      DENY: begin
        if (!req) begin
          state_d = IDLE;
        end else if (permit) begin
          state_d = OPEN;
          cnt_d   = TIMEOUT_INIT;
          class_d = is_uni;
        end
      end
      OPEN: begin
        cnt_d = cnt_q - 8'd1;
        if (pass) begin
          state_d   = COMMIT;
          cnt_d     = 8'd0;
          granted_d = grant;
        end else if (cnt_q <= 8'd1) begin
          state_d = CLOSE;
          cnt_d   = 8'd0;
        end
      end
      COMMIT: begin
        // The arbiter never makes a loser wait twice, so this is one cycle.
        if (granted_q || grant) state_d = CLOSE;
      end
      CLOSE: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only, except the commit request.
  always_comb begin
    gate_open  = (state_q == OPEN);
    denied     = (state_q == DENY);
    commit_req = ((state_q == OPEN) && pass) || ((state_q == COMMIT) && !granted_q);
    car_class  = class_q;
    state_dbg  = state_q;
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit sequencing for the parking counter: class-based admission,
// exit-priority commit arbitration and registered update pulses.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int PASS_TIMEOUT = DEFAULT_PASS_TIMEOUT,
  parameter int W            = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         entry_req,
  input  logic         entry_is_uni,
  input  logic         exit_req,
  input  logic         exit_is_uni,
  input  logic         pass_entry,
  input  logic         pass_exit,
  input  logic         uni_is_vacated_space,
  input  logic         is_vacated_space,
  input  logic [W-1:0] uni_parked_car,
  input  logic [W-1:0] parked_car,
  output logic         car_entered,
  output logic         is_uni_car_entered,
  output logic         car_exited,
  output logic         is_uni_car_exited,
  output logic         entry_gate_open,
  output logic         exit_gate_open,
  output logic         entry_denied,
  output logic         exit_denied
);

  logic       entry_permit, exit_permit;
  logic       entry_commit_req, exit_commit_req;
  logic       entry_class, exit_class;
  logic       entry_grant, exit_grant;
  logic       entry_waiting, exit_waiting;
  logic [2:0] entry_state, exit_state;

  logic car_entered_q, car_entered_d;
  logic is_uni_car_entered_q, is_uni_car_entered_d;
  logic car_exited_q, car_exited_d;
  logic is_uni_car_exited_q, is_uni_car_exited_d;

  // Admission: entry needs a free space of its class, exit a nonzero count.
  always_comb begin
    entry_permit = (entry_is_uni == CLASS_UNI) ? uni_is_vacated_space : is_vacated_space;
    exit_permit  = (exit_is_uni == CLASS_UNI) ? (uni_parked_car != '0) : (parked_car != '0);
  end

  gate_fsm #(.PASS_TIMEOUT(PASS_TIMEOUT)) u_entry (
    .clk        (clk),
    .rst        (rst),
    .req        (entry_req),
    .is_uni     (entry_is_uni),
    .permit     (entry_permit),
    .pass       (pass_entry),
    .grant      (entry_grant),
    .gate_open  (entry_gate_open),
    .denied     (entry_denied),
    .commit_req (entry_commit_req),
    .car_class  (entry_class),
    .state_dbg  (entry_state)
  );

  gate_fsm #(.PASS_TIMEOUT(PASS_TIMEOUT)) u_exit (
    .clk        (clk),
    .rst        (rst),
    .req        (exit_req),
    .is_uni     (exit_is_uni),
    .permit     (exit_permit),
    .pass       (pass_exit),
    .grant      (exit_grant),
    .gate_open  (exit_gate_open),
    .denied     (exit_denied),
    .commit_req (exit_commit_req),
    .car_class  (exit_class),
    .state_dbg  (exit_state)
  );

  // Arbiter: a lane still requesting from COMMIT lost last cycle and goes
  // first; otherwise exit wins a tie.
  always_comb begin
    entry_waiting = entry_commit_req && (entry_state == COMMIT);
    exit_waiting  = exit_commit_req && (exit_state == COMMIT);
    exit_grant    = exit_commit_req && (exit_waiting || !entry_waiting);
    entry_grant   = entry_commit_req && !exit_grant;

    car_entered_d        = entry_grant;
    is_uni_car_entered_d = entry_grant ? entry_class : CLASS_PUBLIC;
    car_exited_d         = exit_grant;
    is_uni_car_exited_d  = exit_grant ? exit_class : CLASS_PUBLIC;
  end

  // Registered one-cycle update pulses and their class qualifiers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car_entered_q        <= 1'b0;
      is_uni_car_entered_q <= 1'b0;
      car_exited_q         <= 1'b0;
      is_uni_car_exited_q  <= 1'b0;
    end else begin
      car_entered_q        <= car_entered_d;
      is_uni_car_entered_q <= is_uni_car_entered_d;
      car_exited_q         <= car_exited_d;
      is_uni_car_exited_q  <= is_uni_car_exited_d;
    end
  end

  assign car_entered        = car_entered_q;
  assign is_uni_car_entered = is_uni_car_entered_q;
  assign car_exited         = car_exited_q;
  assign is_uni_car_exited  = is_uni_car_exited_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed scenarios plus a randomized run
// checked against a behavioural lane model.
module tb_parking_gate_ctrl;

  localparam int T = 16;
  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         entry_req, entry_is_uni, exit_req, exit_is_uni;
  logic         pass_entry, pass_exit;
  logic         uni_is_vacated_space, is_vacated_space;
  logic [W-1:0] uni_parked_car, parked_car;
  logic         car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic         entry_gate_open, exit_gate_open, entry_denied, exit_denied;
  logic [7:0]   outs;

  int checks = 0;
  int errors = 0;

  // Behavioural model state (index 0 = entry lane, 1 = exit lane).
  int   open_left[2];
  bit   deny_m[2], hold_m[2], busy_m[2], won_m[2], cls_m[2];
  bit   exp_ent, exp_ent_uni, exp_ext, exp_ext_uni;

  always #5 clk = ~clk;

  assign outs = {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
                 entry_gate_open, exit_gate_open, entry_denied, exit_denied};

  parking_gate_ctrl #(.PASS_TIMEOUT(T), .W(W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .entry_req            (entry_req),
    .entry_is_uni         (entry_is_uni),
    .exit_req             (exit_req),
    .exit_is_uni          (exit_is_uni),
    .pass_entry           (pass_entry),
    .pass_exit            (pass_exit),
    .uni_is_vacated_space (uni_is_vacated_space),
    .is_vacated_space     (is_vacated_space),
    .uni_parked_car       (uni_parked_car),
    .parked_car           (parked_car),
    .car_entered          (car_entered),
    .is_uni_car_entered   (is_uni_car_entered),
    .car_exited           (car_exited),
    .is_uni_car_exited    (is_uni_car_exited),
    .entry_gate_open      (entry_gate_open),
    .exit_gate_open       (exit_gate_open),
    .entry_denied         (entry_denied),
    .exit_denied          (exit_denied)
  );

  task automatic drive_idle();
    entry_req = 0; entry_is_uni = 0; exit_req = 0; exit_is_uni = 0;
    pass_entry = 0; pass_exit = 0;
    uni_is_vacated_space = 0; is_vacated_space = 0;
    uni_parked_car = '0; parked_car = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      open_left[g] = 0; deny_m[g] = 0; hold_m[g] = 0;
      busy_m[g] = 0; won_m[g] = 0; cls_m[g] = 0;
    end
    exp_ent = 0; exp_ent_uni = 0; exp_ext = 0; exp_ext_uni = 0;
  endtask

  // One clock of the lane model, using the inputs the DUT just sampled.
  task automatic model_step();
    bit req[2], pss[2], permit[2], cl[2], fresh[2], waiting[2], grant[2];
    req[0] = entry_req;  req[1] = exit_req;
    pss[0] = pass_entry; pss[1] = pass_exit;
    cl[0]  = entry_is_uni; cl[1] = exit_is_uni;
    permit[0] = entry_is_uni ? uni_is_vacated_space : is_vacated_space;
    permit[1] = exit_is_uni ? (uni_parked_car != 0) : (parked_car != 0);
    for (int g = 0; g < 2; g++) begin
      fresh[g]   = (open_left[g] > 0) && pss[g];
      waiting[g] = busy_m[g] && !won_m[g];
    end
    // Exit wins a tie, but a lane that already lost once goes first.
    grant[1] = (fresh[1] || waiting[1]) && !waiting[0];
    grant[0] = (fresh[0] || waiting[0]) && !grant[1];
    exp_ent     = grant[0];
    exp_ent_uni = grant[0] && cls_m[0];
    exp_ext     = grant[1];
    exp_ext_uni = grant[1] && cls_m[1];
    for (int g = 0; g < 2; g++) begin
      if (open_left[g] > 0) begin
        if (pss[g]) begin
          open_left[g] = 0; busy_m[g] = 1; won_m[g] = grant[g];
        end else begin
          open_left[g] = open_left[g] - 1;
          if (open_left[g] == 0) hold_m[g] = 1;
        end
      end else if (busy_m[g]) begin
        busy_m[g] = 0; hold_m[g] = 1;
      end else if (hold_m[g]) begin
        if (!req[g]) hold_m[g] = 0;
      end else if (req[g] && permit[g]) begin
        open_left[g] = T; cls_m[g] = cl[g]; deny_m[g] = 0;
      end else begin
        deny_m[g] = req[g];
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1;
    repeat (3) tick();
    checks++;
    if (outs !== 8'h00) begin
      errors++; $display("FAIL reset_idle: got %b expected %b", outs, 8'h00);
    end
    entry_req = 1; uni_is_vacated_space = 1; entry_is_uni = 1;
    exit_req = 1; parked_car = 9'd4;
    tick();
    checks++;
    if (outs !== 8'h00) begin
      errors++; $display("FAIL reset_held_req: got %b expected %b", outs, 8'h00);
    end
    drive_idle();
    rst = 0;
    tick();
    checks++;
    if (outs !== 8'h00) begin
      errors++; $display("FAIL reset_release: got %b expected %b", outs, 8'h00);
    end
  endtask

  task automatic test_uni_entry();
    int open_cnt;
    drive_idle();
    tick();
    uni_is_vacated_space = 1; entry_req = 1; entry_is_uni = 1;
    tick();  // cycle 1
    checks++;
    if (entry_gate_open !== 1'b1) begin
      errors++; $display("FAIL uni_gate_c1: got %b expected 1", entry_gate_open);
    end
    entry_is_uni = 0;  // class must have been latched already
    open_cnt = 0;
    for (int c = 1; c < 5; c++) begin
      tick();
      if (entry_gate_open === 1'b1 && car_entered === 1'b0) open_cnt++;
    end
    checks++;
    if (open_cnt != 4) begin
      errors++; $display("FAIL uni_gate_hold: got %0d expected 4", open_cnt);
    end
    pass_entry = 1;  // cycle 5
    tick();          // cycle 6
    pass_entry = 0;
    checks++;
    if ({car_entered, is_uni_car_entered, entry_gate_open} !== 3'b110) begin
      errors++;
      $display("FAIL uni_commit_c6: got %b expected %b",
               {car_entered, is_uni_car_entered, entry_gate_open}, 3'b110);
    end
    entry_req = 0;
    tick();  // cycle 7
    checks++;
    if ({car_entered, is_uni_car_entered} !== 2'b00) begin
      errors++; $display("FAIL uni_pulse_width: got %b expected 00",
                         {car_entered, is_uni_car_entered});
    end
    tick();
  endtask

  task automatic test_full_lot();
    int deny_cnt;
    drive_idle();
    tick();
    uni_is_vacated_space = 1; is_vacated_space = 0;
    entry_is_uni = 0; entry_req = 1;
    tick();  // cycle 1
    checks++;
    if ({entry_gate_open, entry_denied} !== 2'b01) begin
      errors++; $display("FAIL full_deny_c1: got %b expected 01",
                         {entry_gate_open, entry_denied});
    end
    deny_cnt = 0;
    for (int c = 1; c < 10; c++) begin
      tick();
      if ({entry_gate_open, entry_denied} === 2'b01) deny_cnt++;
    end
    checks++;
    if (deny_cnt != 9) begin
      errors++; $display("FAIL full_deny_hold: got %0d expected 9", deny_cnt);
    end
    is_vacated_space = 1;  // cycle 10
    tick();                // cycle 11
    checks++;
    if ({entry_gate_open, entry_denied} !== 2'b10) begin
      errors++; $display("FAIL full_open_c11: got %b expected 10",
                         {entry_gate_open, entry_denied});
    end
    pass_entry = 1;
    tick();
    pass_entry = 0;
    checks++;
    if ({car_entered, is_uni_car_entered} !== 2'b10) begin
      errors++; $display("FAIL full_public_commit: got %b expected 10",
                         {car_entered, is_uni_car_entered});
    end
    entry_req = 0;
    repeat (2) tick();
  endtask

  task automatic test_simultaneous();
    drive_idle();
    tick();
    uni_is_vacated_space = 1; entry_is_uni = 1; entry_req = 1;
    parked_car = 9'd3; exit_is_uni = 0; exit_req = 1;
    tick();
    checks++;
    if ({entry_gate_open, exit_gate_open} !== 2'b11) begin
      errors++; $display("FAIL sim_both_open: got %b expected 11",
                         {entry_gate_open, exit_gate_open});
    end
    pass_entry = 1; pass_exit = 1;
    tick();
    pass_entry = 0; pass_exit = 0;
    checks++;
    if ({car_entered, car_exited, is_uni_car_exited} !== 3'b010) begin
      errors++; $display("FAIL sim_exit_first: got %b expected 010",
                         {car_entered, car_exited, is_uni_car_exited});
    end
    tick();
    checks++;
    if ({car_entered, is_uni_car_entered, car_exited} !== 3'b110) begin
      errors++; $display("FAIL sim_entry_second: got %b expected 110",
                         {car_entered, is_uni_car_entered, car_exited});
    end
    tick();
    checks++;
    if ({car_entered, car_exited} !== 2'b00) begin
      errors++; $display("FAIL sim_quiet: got %b expected 00", {car_entered, car_exited});
    end
    entry_req = 0; exit_req = 0;
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    int open_cnt, commit_cnt;
    drive_idle();
    tick();
    is_vacated_space = 1; entry_req = 1;
    tick();
    open_cnt = (entry_gate_open === 1'b1) ? 1 : 0;
    commit_cnt = 0;
    for (int i = 0; i < T + 24; i++) begin
      tick();
      if (entry_gate_open === 1'b1) open_cnt++;
      if (car_entered !== 1'b0) commit_cnt++;
    end
    checks++;
    if (open_cnt != T || commit_cnt != 0) begin
      errors++; $display("FAIL timeout_window: got open=%0d commits=%0d expected open=%0d commits=0",
                         open_cnt, commit_cnt, T);
    end
    entry_req = 0;
    tick();
    entry_req = 1;
    tick();
    checks++;
    if (entry_gate_open !== 1'b1) begin
      errors++; $display("FAIL timeout_reopen: got %b expected 1", entry_gate_open);
    end
    entry_req = 0;
    repeat (T + 3) tick();
  endtask

  task automatic test_exit_denied();
    drive_idle();
    tick();
    exit_is_uni = 1; uni_parked_car = '0; parked_car = 9'd5; exit_req = 1;
    tick();
    checks++;
    if ({exit_gate_open, exit_denied} !== 2'b01) begin
      errors++; $display("FAIL exit_deny: got %b expected 01", {exit_gate_open, exit_denied});
    end
    pass_exit = 1;
    tick();
    pass_exit = 0;
    checks++;
    if ({car_exited, exit_denied} !== 2'b01) begin
      errors++; $display("FAIL exit_deny_nopulse: got %b expected 01", {car_exited, exit_denied});
    end
    exit_req = 0;
    tick();
    checks++;
    if (exit_denied !== 1'b0) begin
      errors++; $display("FAIL exit_deny_clear: got %b expected 0", exit_denied);
    end
  endtask

  task automatic test_reset_mid_open();
    drive_idle();
    tick();
    is_vacated_space = 1; entry_req = 1;
    repeat (3) tick();
    checks++;
    if (entry_gate_open !== 1'b1) begin
      errors++; $display("FAIL rst_mid_open_pre: got %b expected 1", entry_gate_open);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (outs !== 8'h00) begin
      errors++; $display("FAIL rst_mid_open_async: got %b expected %b", outs, 8'h00);
    end
    entry_req = 0;
    tick();
    rst = 0;
    pass_entry = 1;
    tick();
    pass_entry = 0;
    tick();
    checks++;
    if (outs !== 8'h00) begin
      errors++; $display("FAIL rst_mid_open_after: got %b expected %b", outs, 8'h00);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_v;
    int bad;
    drive_idle();
    rst = 1;
    tick();
    rst = 0;
    model_reset();
    bad = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(7) == 0) entry_req = ~entry_req;
      if ($urandom_range(7) == 0) exit_req = ~exit_req;
      entry_is_uni = 1'($urandom_range(1));
      exit_is_uni  = 1'($urandom_range(1));
      pass_entry   = ($urandom_range(5) == 0);
      pass_exit    = ($urandom_range(5) == 0);
      if ($urandom_range(4) == 0) uni_is_vacated_space = ~uni_is_vacated_space;
      if ($urandom_range(4) == 0) is_vacated_space = ~is_vacated_space;
      if ($urandom_range(9) == 0) uni_parked_car = W'($urandom_range(2));
      if ($urandom_range(9) == 0) parked_car = W'($urandom_range(2));
      @(posedge clk);
      model_step();
      #1;
      exp_v = {exp_ent, exp_ent_uni, exp_ext, exp_ext_uni,
               open_left[0] > 0, open_left[1] > 0, deny_m[0], deny_m[1]};
      checks++;
      if (outs !== exp_v) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_cycle %0d: got %b expected %b", cyc, outs, exp_v);
        bad++;
      end
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_uni_entry();
    test_full_lot();
    test_simultaneous();
    test_timeout();
    test_exit_denied();
    test_reset_mid_open();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
